// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller and decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Patterns are active-low. Bit order is {a,b,c,d,e,f,g,dp}, with bit 7 = a.
package ssd_pkg;

    localparam logic [7:0] SS_0     = 8'h03;
    localparam logic [7:0] SS_1     = 8'h9F;
    localparam logic [7:0] SS_2     = 8'h25;
    localparam logic [7:0] SS_3     = 8'h0D;
    localparam logic [7:0] SS_4     = 8'h99;
    localparam logic [7:0] SS_5     = 8'h49;
    localparam logic [7:0] SS_6     = 8'h41;
    localparam logic [7:0] SS_7     = 8'h1B;
    localparam logic [7:0] SS_8     = 8'h01;
    localparam logic [7:0] SS_9     = 8'h09;
    localparam logic [7:0] SS_A     = 8'h11;
    localparam logic [7:0] SS_B     = 8'hC1;
    localparam logic [7:0] SS_C     = 8'h63;
    localparam logic [7:0] SS_D     = 8'h85;
    localparam logic [7:0] SS_E     = 8'h61;
    localparam logic [7:0] SS_F     = 8'h71;
    localparam logic [7:0] SS_BLANK = 8'hFF;

    // Index of the digit currently being scanned (0 = rightmost digit).
    typedef logic [1:0] digit_idx_t;

    // Return the nibble of a 16-bit display word that belongs to digit 'idx'.
    function automatic logic [3:0] digit_nibble(input logic [15:0] val, input digit_idx_t idx);
        logic [3:0] nib;
        nib = val[3:0];
        case (idx)
            2'd0: nib = val[3:0];
            2'd1: nib = val[7:4];
            2'd2: nib = val[11:8];
            2'd3: nib = val[15:12];
            default: nib = val[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Bundles the datapath-facing load port and the display pins of the scan controller.
// Latency: n/a (wiring only).
// Backpressure: none. A load is always accepted. busy only reports that a value is still pending.
// Modports:
//   master : the datapath side. It drives load/din and observes busy, frame_done and the pins.
//   slave  : the controller side.
interface ssd_scan_ctrl_if;
    logic        load;
    logic [15:0] din;
    logic        busy;
    logic        frame_done;
    logic [7:0]  D;
    logic [3:0]  ssd_active;

    modport master (
        output load, din,
        input  busy, frame_done, D, ssd_active
    );

    modport slave (
        input  load, din,
        output busy, frame_done, D, ssd_active
    );
endinterface

// File: rtl/ssd_decoder.sv
// Converts a hex nibble to an active-low seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: nibble (4-bit input value), seg (8-bit pattern {a,b,c,d,e,f,g,dp}, active-low).
module ssd_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SS_BLANK;
        case (nibble)
            4'h0: seg = SS_0;
            4'h1: seg = SS_1;
            4'h2: seg = SS_2;
            4'h3: seg = SS_3;
            4'h4: seg = SS_4;
            4'h5: seg = SS_5;
            4'h6: seg = SS_6;
            4'h7: seg = SS_7;
            4'h8: seg = SS_8;
            4'h9: seg = SS_9;
            4'hA: seg = SS_A;
            4'hB: seg = SS_B;
            4'hC: seg = SS_C;
            4'hD: seg = SS_D;
            4'hE: seg = SS_E;
            4'hF: seg = SS_F;
            default: seg = SS_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Scans a 4-digit active-low seven-segment display and changes the shown value only at frame boundaries.
// Latency: D/ssd_active follow idx/disp one cycle later. A load is shown from the next frame (or this frame if loaded on the wrap cycle).
// Backpressure: none. Every load is accepted, and a newer pending load replaces an older one. busy marks a pending value.
// Ports: clk, rst (synchronous, active-high), bus (ssd_scan_ctrl_if.slave: load/din in; busy/frame_done/D/ssd_active out).
// Parameter: REFRESH_DIV = number of clk cycles each digit stays lit (at least 2).
// Optional: define SSD_LZB_EN to enable leading-zero blanking of digits 3..1.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    ssd_scan_ctrl_if.slave   bus
);

    localparam int              CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    logic [15:0]   disp;
    logic [15:0]   pending;
    logic          pend_v;
    logic          frame_done_q;
    logic [7:0]    d_q;
    logic [3:0]    act_q;

    logic          tick;
    logic          apply;
    logic [3:0]    cur_nibble;
    logic [7:0]    dec_seg;
    logic [7:0]    seg_next;

    assign tick  = (cnt == CNT_MAX);
    // The wrap from digit 3 to digit 0 is the only point where disp may change.
    assign apply = tick && (idx == 2'd3);

    assign cur_nibble = digit_nibble(disp, idx);

    ssd_decoder u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef SSD_LZB_EN
    // Digit k (k >= 1) goes dark when it and every digit to its left are zero.
    // Digit 0 always shows, so a zero value still displays a single "0".
    logic lead_zero;
    always_comb begin
        lead_zero = 1'b0;
        case (idx)
            2'd1: lead_zero = (disp[15:4]  == 12'h000);
            2'd2: lead_zero = (disp[15:8]  == 8'h00);
            2'd3: lead_zero = (disp[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    end
    assign seg_next = lead_zero ? SS_BLANK : dec_seg;
`else
    assign seg_next = dec_seg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 2'd0;
            disp         <= 16'h0000;
            pending      <= 16'h0000;
            pend_v       <= 1'b0;
            frame_done_q <= 1'b0;
            d_q          <= SS_BLANK;
            act_q        <= 4'hF;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end

            // Pins follow the current scan position one cycle later.
            act_q <= ~(4'b0001 << idx);
            d_q   <= seg_next;

            frame_done_q <= apply;

            if (apply) begin
                // A load on the wrap cycle goes straight to the display. It takes
                // precedence over any older pending value, which is discarded.
                if (bus.load) begin
                    disp <= bus.din;
                end else if (pend_v) begin
                    disp <= pending;
                end
                pend_v <= 1'b0;
            end else if (bus.load) begin
                pending <= bus.din;
                pend_v  <= 1'b1;
            end
        end
    end

    assign bus.busy       = pend_v;
    assign bus.frame_done = frame_done_q;
    assign bus.D          = d_q;
    assign bus.ssd_active = act_q;

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit, active-low seven-segment display on the comparator lab boards. It latches a 16-bit hex value (four nibbles) from the datapath and cycles through the four digit enables at a divided refresh rate, driving the segment bus D for the lit digit. New values are applied only at frame boundaries, so no digit ever shows a mix of old and new values within one frame. It sits between the comparator/arithmetic datapaths and the board's shared D/ssd_active pins.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range is 2 or more.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
load  input  1  one-cycle strobe; captures din
din  input  16  display value; din[3:0] goes to digit0 (ssd_active[0], rightmost), din[15:12] goes to digit3
busy  output  1  a loaded value is pending and not yet displayed
frame_done  output  1  one-cycle pulse when the scan wraps from digit3 to digit0
D  output  8  segments {a,b,c,d,e,f,g,dp}, active-low
ssd_active  output  4  digit enables, active-low, one-hot-zero

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - Divider cnt=0, digit index idx=0, displayed register disp=16'h0000, pending=0, pend_v=0.
  - Outputs: D=8'hFF, ssd_active=4'hF, busy=0, frame_done=0.
- Divider:
  - cnt counts from 0 to REFRESH_DIV-1 and then wraps to 0.
  - tick is asserted when cnt==REFRESH_DIV-1.
  - On tick, idx increments modulo 4 (3 wraps to 0).
- Outputs D and ssd_active are registered:
  - Each cycle, ssd_active <= ~(4'b0001<<idx) and D <= seg(disp nibble[idx]).
  - This gives one cycle of latency from an idx/disp change to the pins.
  - First cycle after reset deassertion: ssd_active=4'b1110, D=8'b0000_0011.
- Apply event: tick with idx==3. On that cycle:
  - frame_done <= 1.
  - If pend_v, then disp <= pending and pend_v <= 0.
- Load rules:
  - load on a non-apply cycle: pending <= din, pend_v <= 1. A load while pend_v==1 overwrites pending (newest wins).
  - load on the apply cycle: disp <= din directly and pend_v <= 0. Any older pending value is discarded.
- busy = pend_v (registered).
- Segment encoding, active-low, bit7=a ... bit0=dp:
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1B
  - 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71 (hex)
- Reset mid-frame returns to the reset state; pending data is lost.

Optional Feature:
Macro SSD_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k=3..1) is blanked (D=8'hFF, enable still driven normally) when disp nibbles k through 3 are all zero.
  - Digit0 is never blanked.
- Undefined: all four digits are always decoded.

Decomposition:
- Package ssd_pkg holds:
  - Constants SS_0..SS_F (8-bit, values above) and SS_BLANK=8'hFF.
  - Typedef digit_idx_t (2-bit).
- One sub-module, ssd_decoder: 4-bit nibble in, 8-bit active-low pattern out. It is purely combinational, built as a case over ssd_pkg constants, and is reusable by other lab blocks.

Test Plan:
Use REFRESH_DIV=4 for all scenarios.
1. Reset and scan order: hold rst 3 cycles.
   - During reset: D=FF, ssd_active=F, busy=0.
   - After release: ssd_active sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; D=03 throughout; frame_done pulses every 16 cycles.
2. Frame-synchronous load: load din=16'h3A7F while idx=1.
   - busy=1 until the wrap, and the current frame still shows 0.
   - Next frame: digit0 D=71, digit1 D=1B, digit2 D=11, digit3 D=0D; busy=0.
3. Overwrite: load 16'h1111, then 16'h2222, in the same frame.
   - Only 2222 is displayed (D=25 on all digits); 1111 never appears.
4. Load on apply cycle: load 16'hBEEF in the cycle with tick and idx==3.
   - Next frame: digit0 D=71, digit1 D=61, digit2 D=61, digit3 D=C1.
   - busy stays 0.
5. Reset mid-operation: load 16'hFFFF, then assert rst before the wrap.
   - Pending value is dropped, busy=0, and the display shows 0 on all digits after release.
6. SSD_LZB_EN defined:
   - din=16'h0050 gives digit3=FF, digit2=FF, digit1=49, digit0=03.
   - din=16'h0000 gives digit0=03 and the others FF.
   - With the macro undefined, the same inputs show 03 on all blanked positions.
